// File: rtl/sme_pe_scheduler.sv
// Round-based scheduler for the SME PE array: issues NUM_PE positions per round and
// reduces each round's hits through the min-index comparator. Optional WAIT_PE watchdog: SME_PE_TIMEOUT_EN.
module sme_pe_scheduler #(
  parameter int NUM_PE      = 8,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W:0]              win_len,
  output logic [NUM_PE-1:0]            pe_start,
  output logic [NUM_PE*ADDR_W-1:0]     pe_pos,
  input  logic [NUM_PE-1:0]            pe_done,
  input  logic [NUM_PE-1:0]            pe_hit,
  output logic [NUM_PE*(ADDR_W+1)-1:0] cmp_result_vec,
  output logic                         cmp_valid,
  input  logic                         cmp_o_valid,
  input  logic [ADDR_W-1:0]            cmp_result,
  output logic                         busy,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         found,
  output logic [ADDR_W-1:0]            match_pos,
  output logic                         err
);

  localparam int LANE_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, DISPATCH, WAIT_PE, CMP_REQ, CMP_WAIT, CMP_RELEASE, RESULT
  } state_e;

  state_e              state_q;
  logic [ADDR_W:0]     winLen_q;
  logic [ADDR_W:0]     base_q;
  logic [NUM_PE-1:0]   done_q;
  logic [NUM_PE-1:0]   hit_q;
  logic                anyHit_q;
  logic [ADDR_W-1:0]   roundMin_q;

  logic [ADDR_W:0]     lanePos_d [NUM_PE];
  logic [NUM_PE-1:0]   laneActive_d;
  logic [ADDR_W+1:0]   nextBase_d;
  logic                lastRound_d;

`ifdef SME_PE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] waitCnt_q;
  logic             err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy = (state_q != IDLE);

  // Positions are one bit wider than ADDR_W so the last round's tail lanes compare correctly against win_len.
  always_comb begin
    for (int k = 0; k < NUM_PE; k++) begin
      lanePos_d[k]    = base_q + LANE_W'(k);
      laneActive_d[k] = (lanePos_d[k] < winLen_q);
    end
    nextBase_d  = {1'b0, base_q} + (ADDR_W+2)'(NUM_PE);
    lastRound_d = (nextBase_d >= {1'b0, winLen_q});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      winLen_q       <= '0;
      base_q         <= '0;
      done_q         <= '0;
      hit_q          <= '0;
      anyHit_q       <= 1'b0;
      roundMin_q     <= '0;
      pe_start       <= '0;
      pe_pos         <= '0;
      cmp_result_vec <= '0;
      cmp_valid      <= 1'b0;
      res_valid      <= 1'b0;
      found          <= 1'b0;
      match_pos      <= '0;
`ifdef SME_PE_TIMEOUT_EN
      waitCnt_q      <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      pe_start <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            winLen_q <= win_len;
            base_q   <= '0;
`ifdef SME_PE_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            if (win_len == '0) begin
              found     <= 1'b0;
              match_pos <= '0;
              res_valid <= 1'b1;
              state_q   <= RESULT;
            end else begin
              state_q <= DISPATCH;
            end
          end
        end

        // Inactive lanes start out done so they never hold up the round.
        DISPATCH: begin
          pe_start <= laneActive_d;
          for (int k = 0; k < NUM_PE; k++) begin
            pe_pos[k*ADDR_W +: ADDR_W] <= lanePos_d[k][ADDR_W-1:0];
          end
          done_q  <= ~laneActive_d;
          hit_q   <= '0;
`ifdef SME_PE_TIMEOUT_EN
          waitCnt_q <= '0;
`endif
          state_q <= WAIT_PE;
        end

        WAIT_PE: begin
          for (int k = 0; k < NUM_PE; k++) begin
            if (pe_done[k] && !done_q[k]) begin
              done_q[k] <= 1'b1;
              hit_q[k]  <= pe_hit[k];
            end
          end
          if (&done_q) state_q <= CMP_REQ;
`ifdef SME_PE_TIMEOUT_EN
          else if (waitCnt_q == CNT_W'(TIMEOUT_CYC)) begin
            done_q  <= '1;
            err_q   <= 1'b1;
            state_q <= CMP_REQ;
          end else begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
`endif
        end

        // {~hit, pos} makes any hit sort below every miss; idle lanes are all-ones so they never win.
        CMP_REQ: begin
          for (int k = 0; k < NUM_PE; k++) begin
            cmp_result_vec[k*LANE_W +: LANE_W] <= laneActive_d[k] ?
                {~hit_q[k], lanePos_d[k][ADDR_W-1:0]} : {LANE_W{1'b1}};
          end
          anyHit_q  <= |hit_q;
          cmp_valid <= 1'b1;
          state_q   <= CMP_WAIT;
        end

        CMP_WAIT: begin
          if (cmp_o_valid) begin
            roundMin_q <= cmp_result;
            cmp_valid  <= 1'b0;
            state_q    <= CMP_RELEASE;
          end
        end

        CMP_RELEASE: begin
          if (!cmp_o_valid) begin
            if (anyHit_q) begin
              found     <= 1'b1;
              match_pos <= roundMin_q;
              res_valid <= 1'b1;
              state_q   <= RESULT;
            end else if (lastRound_d) begin
              found     <= 1'b0;
              match_pos <= '0;
              res_valid <= 1'b1;
              state_q   <= RESULT;
            end else begin
              base_q  <= nextBase_d[ADDR_W:0];
              state_q <= DISPATCH;
            end
          end
        end

        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            found     <= 1'b0;
            match_pos <= '0;
            state_q   <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_pe_scheduler.sv
// Directed bench for sme_pe_scheduler with behavioural PE-array and min-index comparator models.
module tb_sme_pe_scheduler;

  localparam int NUM_PE = 8;
  localparam int ADDR_W = 5;
  localparam int LANE_W = ADDR_W + 1;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       start;
  logic [ADDR_W:0]            win_len;
  logic [NUM_PE-1:0]          pe_start;
  logic [NUM_PE*ADDR_W-1:0]   pe_pos;
  logic [NUM_PE-1:0]          pe_done;
  logic [NUM_PE-1:0]          pe_hit;
  logic [NUM_PE*LANE_W-1:0]   cmp_result_vec;
  logic                       cmp_valid;
  logic                       cmp_o_valid;
  logic [ADDR_W-1:0]          cmp_result;
  logic                       busy;
  logic                       res_valid;
  logic                       res_ready;
  logic                       found;
  logic [ADDR_W-1:0]          match_pos;
  logic                       err;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0]       hitMap = '0;
  logic [NUM_PE-1:0] neverLane = '0;
  int                holdCyc = 0;

  int                dispatchCount = 0;
  logic [7:0]        startLog [4];
  int                cmpCount = 0;
  logic [NUM_PE*LANE_W-1:0] vecLog [4];
  int                overlapErr = 0;
  int                vecChangeErr = 0;

  sme_pe_scheduler #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .reset(reset), .start(start), .win_len(win_len),
    .pe_start(pe_start), .pe_pos(pe_pos), .pe_done(pe_done), .pe_hit(pe_hit),
    .cmp_result_vec(cmp_result_vec), .cmp_valid(cmp_valid),
    .cmp_o_valid(cmp_o_valid), .cmp_result(cmp_result),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .found(found), .match_pos(match_pos), .err(err)
  );

  always #5 clk = ~clk;

  // PE array: each launched lane answers after (k mod 3) cycles, hit looked up from hitMap.
  logic [NUM_PE-1:0] laneBusy = '0;
  int                laneCnt [NUM_PE];
  logic [ADDR_W-1:0] lanePosM [NUM_PE];

  always @(negedge clk) begin
    pe_done = '0;
    pe_hit  = '0;
    if (reset) begin
      laneBusy = '0;
    end else begin
      for (int k = 0; k < NUM_PE; k++) begin
        if (laneBusy[k]) begin
          if (laneCnt[k] == 0) begin
            pe_done[k]  = 1'b1;
            pe_hit[k]   = hitMap[lanePosM[k]];
            laneBusy[k] = 1'b0;
          end else begin
            laneCnt[k] = laneCnt[k] - 1;
          end
        end
      end
      if (pe_start != '0) begin
        if (dispatchCount < 4) startLog[dispatchCount] = pe_start;
        dispatchCount++;
        for (int k = 0; k < NUM_PE; k++) begin
          if (pe_start[k] && !neverLane[k]) begin
            laneBusy[k] = 1'b1;
            laneCnt[k]  = k % 3;
            lanePosM[k] = pe_pos[k*ADDR_W +: ADDR_W];
          end
        end
      end
    end
  end

  function automatic logic [ADDR_W-1:0] minOf(input logic [NUM_PE*LANE_W-1:0] v);
    logic [LANE_W-1:0] m;
    m = '1;
    for (int k = 0; k < NUM_PE; k++)
      if (v[k*LANE_W +: LANE_W] < m) m = v[k*LANE_W +: LANE_W];
    return m[ADDR_W-1:0];
  endfunction

  // Comparator: answers one cycle after i_valid, keeps o_valid up holdCyc+1 cycles after i_valid drops.
  int   cmpState = 0;
  int   holdLeft = 0;
  logic cmpValidPrev = 1'b0;
  logic [NUM_PE*LANE_W-1:0] heldVec = '0;

  always @(negedge clk) begin
    if (reset) begin
      cmpState     = 0;
      cmp_o_valid  = 1'b0;
      cmp_result   = '0;
      cmpValidPrev = 1'b0;
    end else begin
      if (cmp_valid && !cmpValidPrev) begin
        if (cmp_o_valid) overlapErr++;
        if (cmpCount < 4) vecLog[cmpCount] = cmp_result_vec;
        cmpCount++;
        heldVec = cmp_result_vec;
      end else if (cmp_valid && cmp_result_vec != heldVec) begin
        vecChangeErr++;
      end
      case (cmpState)
        0: if (cmp_valid) cmpState = 1;
        1: begin
          cmp_o_valid = 1'b1;
          cmp_result  = minOf(cmp_result_vec);
          cmpState    = 2;
        end
        2: if (!cmp_valid) begin
          holdLeft = holdCyc;
          cmpState = 3;
        end
        default: begin
          if (holdLeft == 0) begin
            cmp_o_valid = 1'b0;
            cmpState    = 0;
          end else begin
            holdLeft = holdLeft - 1;
          end
        end
      endcase
      cmpValidPrev = cmp_valid;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [ADDR_W:0] winLen, input logic [31:0] hits,
                               input logic [NUM_PE-1:0] never, input int hold);
    hitMap        = hits;
    neverLane     = never;
    holdCyc       = hold;
    dispatchCount = 0;
    cmpCount      = 0;
    overlapErr    = 0;
    vecChangeErr  = 0;
    win_len       = winLen;
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
  endtask

  task automatic waitResult(input int maxCyc, output int cyc);
    cyc = 0;
    while (!res_valid && cyc < maxCyc) begin
      @(negedge clk);
      cyc++;
    end
    if (!res_valid) checkOutput("resultTimeout", 64'd0, 64'd1);
  endtask

  task automatic ackResult();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
    checkOutput({tag, ".pe_start"}, 64'(pe_start), 64'd0);
    checkOutput({tag, ".pe_pos"}, 64'(pe_pos), 64'd0);
    checkOutput({tag, ".cmp_valid"}, 64'(cmp_valid), 64'd0);
    checkOutput({tag, ".cmp_vec"}, 64'(cmp_result_vec), 64'd0);
    checkOutput({tag, ".res_valid"}, 64'(res_valid), 64'd0);
    checkOutput({tag, ".found"}, 64'(found), 64'd0);
    checkOutput({tag, ".match_pos"}, 64'(match_pos), 64'd0);
    checkOutput({tag, ".err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int cyc;
    reset     = 1'b1;
    start     = 1'b0;
    win_len   = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] hits at 13 and 18, win_len=20");
    applyStimulus(6'd20, 32'h0004_2000, '0, 0);
    waitResult(200, cyc);
    repeat (3) @(negedge clk);
    checkOutput("t1.found", 64'(found), 64'd1);
    checkOutput("t1.match_pos", 64'(match_pos), 64'd13);
    checkOutput("t1.dispatches", 64'(dispatchCount), 64'd2);
    checkOutput("t1.cmpTxns", 64'(cmpCount), 64'd2);
    checkOutput("t1.start0", 64'(startLog[0]), 64'hFF);
    checkOutput("t1.start1", 64'(startLog[1]), 64'hFF);
    checkOutput("t1.overlap", 64'(overlapErr), 64'd0);
    ackResult();
    checkOutput("t1.idleBusy", 64'(busy), 64'd0);
    checkOutput("t1.idleValid", 64'(res_valid), 64'd0);

    $display("[TB] no hits, win_len=20, comparator holds o_valid");
    applyStimulus(6'd20, 32'h0, '0, 2);
    waitResult(300, cyc);
    checkOutput("t2.found", 64'(found), 64'd0);
    checkOutput("t2.match_pos", 64'(match_pos), 64'd0);
    checkOutput("t2.dispatches", 64'(dispatchCount), 64'd3);
    checkOutput("t2.start2", 64'(startLog[2]), 64'h0F);
    checkOutput("t2.vec2", 64'(vecLog[2]), {16'h0, 24'hFFFFFF, 24'hCF2C70});
    checkOutput("t2.overlap", 64'(overlapErr), 64'd0);
    checkOutput("t2.vecStable", 64'(vecChangeErr), 64'd0);
    ackResult();

    $display("[TB] empty window");
    applyStimulus(6'd0, 32'hFFFF_FFFF, '0, 0);
    waitResult(5, cyc);
    checkOutput("t3.latency", 64'(cyc <= 2), 64'd1);
    checkOutput("t3.res_valid", 64'(res_valid), 64'd1);
    checkOutput("t3.found", 64'(found), 64'd0);
    checkOutput("t3.dispatches", 64'(dispatchCount), 64'd0);
    checkOutput("t3.cmpTxns", 64'(cmpCount), 64'd0);
    ackResult();

    $display("[TB] result back-pressure with start pulses");
    applyStimulus(6'd5, 32'h0000_0014, '0, 0);
    waitResult(100, cyc);
    checkOutput("t4.start0", 64'(startLog[0]), 64'h1F);
    for (int i = 0; i < 5; i++) begin
      start   = 1'b1;
      win_len = 6'd3;
      @(negedge clk);
      checkOutput("t4.heldValid", 64'(res_valid), 64'd1);
      checkOutput("t4.heldFound", 64'(found), 64'd1);
      checkOutput("t4.heldPos", 64'(match_pos), 64'd2);
    end
    start = 1'b0;
    checkOutput("t4.startIgnored", 64'(dispatchCount), 64'd1);
    ackResult();
    checkOutput("t4.idleValid", 64'(res_valid), 64'd0);
    checkOutput("t4.idleBusy", 64'(busy), 64'd0);

    $display("[TB] reset while waiting on a stuck lane");
    applyStimulus(6'd20, 32'h0, 8'h08, 0);
    repeat (6) @(negedge clk);
    checkOutput("t5.busyBefore", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("t5");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("t5.noResult", 64'(res_valid), 64'd0);

`ifdef SME_PE_TIMEOUT_EN
    $display("[TB] watchdog: lane 3 silent, hit at 5");
    applyStimulus(6'd8, 32'h0000_0020, 8'h08, 0);
    waitResult(100, cyc);
    checkOutput("t6.err", 64'(err), 64'd1);
    checkOutput("t6.found", 64'(found), 64'd1);
    checkOutput("t6.match_pos", 64'(match_pos), 64'd5);
    ackResult();
    neverLane = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
